// File: rtl/irrigation_pkg.sv
// Shared types, default timing constants and counter sizing for the irrigation sequencer.
package irrigation_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SPRINKLE,
      DRIP,
      COOLDOWN,
      FAULT
   } state_t;

   localparam int DEF_DEBOUNCE        = 4;
   localparam int DEF_SPRINKLE_CYCLES = 20;
   localparam int DEF_DRIP_CYCLES     = 30;
   localparam int DEF_COOLDOWN_CYCLES = 10;
   localparam int DEF_FILL_MAX        = 50;

   // Bits needed to hold 0..max_val without wrapping.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/irrigation_sequencer_debouncer.sv
// Single-bit input conditioner: 2-flop synchronizer followed by a stability debouncer.
module sensor_debouncer
   import irrigation_pkg::*;
#(
   parameter int DEBOUNCE = DEF_DEBOUNCE
)(
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic filt
);

   localparam int CW = cnt_width(DEBOUNCE);

   logic          sync_a;
   logic          sync_b;
   logic [CW-1:0] cnt;

   // cnt holds the remaining cycles sync_b must disagree with filt before filt follows it.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_a <= 1'b0;
         sync_b <= 1'b0;
         cnt    <= '0;
         filt   <= 1'b0;
      end else begin
         sync_a <= raw;
         sync_b <= sync_a;
         if (sync_b == filt) begin
            cnt <= CW'(DEBOUNCE - 1);
         end else if (cnt == '0) begin
            filt <= sync_b;
            cnt  <= CW'(DEBOUNCE - 1);
         end else begin
            cnt <= cnt - CW'(1);
         end
      end
   end

endmodule

// File: rtl/irrigation_sequencer.sv
// Tank fill and irrigation sequencer: debounced sensors, irrigation FSM with run/cooldown
// timer, and an independent supply-valve controller with a sticky fill timeout.
//
// state    | meaning
// IDLE     | waiting for a dry-soil request with water above mid
// SPRINKLE | sprinkler run (cool, humid air)
// DRIP     | dripper run (hot or dry air)
// COOLDOWN | mandatory rest after any run, requests ignored
// FAULT    | level sensors inconsistent, all irrigation off
module irrigation_sequencer
   import irrigation_pkg::*;
#(
   parameter int DEBOUNCE        = DEF_DEBOUNCE,
   parameter int SPRINKLE_CYCLES = DEF_SPRINKLE_CYCLES,
   parameter int DRIP_CYCLES     = DEF_DRIP_CYCLES,
   parameter int COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES,
   parameter int FILL_MAX        = DEF_FILL_MAX
)(
   input  logic clk,
   input  logic rst,
   input  logic low,
   input  logic mid,
   input  logic high,
   input  logic Us,
   input  logic Ua,
   input  logic T,
   output logic watter_supply,
   output logic error,
   output logic alarme,
   output logic asp,
   output logic got
);

   localparam int RUN_MAX_A = (SPRINKLE_CYCLES > DRIP_CYCLES) ? SPRINKLE_CYCLES : DRIP_CYCLES;
   localparam int RUN_MAX   = (RUN_MAX_A > COOLDOWN_CYCLES) ? RUN_MAX_A : COOLDOWN_CYCLES;
   localparam int RW        = cnt_width(RUN_MAX);
   localparam int FW        = cnt_width(FILL_MAX);

   logic          fl, fm, fh, fus, fua, ft;
   logic          bad;
   state_t        state;
   logic [RW-1:0] run_tmr;
   logic          fill;
   logic          to_latched;
   logic [FW-1:0] fill_cnt;

   sensor_debouncer #(.DEBOUNCE(DEBOUNCE)) u_db_low  (.clk(clk), .rst(rst), .raw(low),  .filt(fl));
   sensor_debouncer #(.DEBOUNCE(DEBOUNCE)) u_db_mid  (.clk(clk), .rst(rst), .raw(mid),  .filt(fm));
   sensor_debouncer #(.DEBOUNCE(DEBOUNCE)) u_db_high (.clk(clk), .rst(rst), .raw(high), .filt(fh));
   sensor_debouncer #(.DEBOUNCE(DEBOUNCE)) u_db_us   (.clk(clk), .rst(rst), .raw(Us),   .filt(fus));
   sensor_debouncer #(.DEBOUNCE(DEBOUNCE)) u_db_ua   (.clk(clk), .rst(rst), .raw(Ua),   .filt(fua));
   sensor_debouncer #(.DEBOUNCE(DEBOUNCE)) u_db_t    (.clk(clk), .rst(rst), .raw(T),    .filt(ft));

   assign bad = (fm & ~fl) | (fh & ~fm);

   // Outputs are registered alongside the state so they change with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         run_tmr <= '0;
         asp     <= 1'b0;
         got     <= 1'b0;
         error   <= 1'b0;
      end else if (bad) begin
         state   <= FAULT;
         run_tmr <= '0;
         asp     <= 1'b0;
         got     <= 1'b0;
         error   <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (fus && fm) begin
                  run_tmr <= (fua || ft) ? RW'(DRIP_CYCLES - 1) : RW'(SPRINKLE_CYCLES - 1);
                  state   <= (fua || ft) ? DRIP : SPRINKLE;
                  got     <= fua || ft;
                  asp     <= !(fua || ft);
               end
            end
            SPRINKLE, DRIP: begin
               if (run_tmr == '0 || !fm) begin
                  state   <= COOLDOWN;
                  run_tmr <= RW'(COOLDOWN_CYCLES - 1);
                  asp     <= 1'b0;
                  got     <= 1'b0;
               end else begin
                  run_tmr <= run_tmr - RW'(1);
               end
            end
            COOLDOWN: begin
               if (run_tmr == '0) begin
                  state <= IDLE;
               end else begin
                  run_tmr <= run_tmr - RW'(1);
               end
            end
            FAULT: begin
               state <= IDLE;
               error <= 1'b0;
            end
            default: begin
               state   <= IDLE;
               run_tmr <= '0;
               asp     <= 1'b0;
               got     <= 1'b0;
               error   <= 1'b0;
            end
         endcase
      end
   end

   // A full tank (fh) is checked before the timeout so a coincident arrival never latches.
   always_ff @(posedge clk) begin
      if (rst) begin
         fill       <= 1'b0;
         fill_cnt   <= '0;
         to_latched <= 1'b0;
      end else if (fill) begin
         if (fh || bad) begin
            fill     <= 1'b0;
            fill_cnt <= '0;
         end else if (fill_cnt == FW'(FILL_MAX - 1)) begin
            fill       <= 1'b0;
            fill_cnt   <= '0;
            to_latched <= 1'b1;
         end else begin
            fill_cnt <= fill_cnt + FW'(1);
         end
      end else begin
         fill_cnt <= '0;
         if (!fl && !bad && !to_latched) begin
            fill <= 1'b1;
         end
      end
   end

   assign watter_supply = fill;
   assign alarme        = error | to_latched;

endmodule
